imem_loader: RTL



---
 rtl/imem_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream -> little-endian 32-bit words written from word 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader #(
    parameter int unsigned NUM_INSTR = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StCount, StData, StWrite, StCheck, StDone, StErr} state_e;
    logic [7:0] csum_q;
`else
    typedef enum logic [2:0] {StIdle, StCount, StData, StWrite, StDone, StErr} state_e;
`endif

    state_e     state_q;
    logic [7:0] count_q;
    logic [7:0] word_idx_q;
    logic [1:0] byte_idx_q;
    logic       accept;
    logic       last_word;

    assign accept    = byte_valid & byte_ready;
    assign last_word = (word_idx_q + 8'd1) == count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            count_q    <= 8'd0;
            word_idx_q <= 8'd0;
            byte_idx_q <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            core_rst_n <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_q)
                // A start from ERR is treated exactly like a start from IDLE.
                StIdle, StErr: begin
                    if (start) begin
                        state_q    <= StCount;
                        err        <= 1'b0;
                        word_idx_q <= 8'd0;
                        byte_idx_q <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= 8'd0;
`endif
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        core_rst_n <= 1'b0;
                    end
                end
                StCount: begin
                    if (accept) begin
                        if (byte_in == 8'd0 || 32'(byte_in) > NUM_INSTR) begin
                            state_q    <= StErr;
                            err        <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            count_q <= byte_in;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        wr_data[{byte_idx_q, 3'b000} +: 8] <= byte_in;
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ byte_in;
`endif
                        if (byte_idx_q == 2'd3) begin
                            state_q    <= StWrite;
                            byte_ready <= 1'b0;
                            wr_en      <= 1'b1;
                            wr_addr    <= ADDR_W'({word_idx_q, 2'b00});
                        end
                    end
                end
                StWrite: begin
                    wr_en      <= 1'b0;
                    word_idx_q <= word_idx_q + 8'd1;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= StCheck;
                        byte_ready <= 1'b1;
`else
                        state_q    <= StDone;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                        busy       <= 1'b0;
`endif
                    end else begin
                        state_q    <= StData;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // Memory is already written; a bad checksum keeps the core held in reset.
                StCheck: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_in == csum_q) begin
                            state_q    <= StDone;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state_q <= StErr;
                            err     <= 1'b1;
                        end
                    end
                end
`endif
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
